// File: rtl/r_issue_stage.sv
// Decode/issue stage ahead of the R-type ALU: validates the instruction, reads operands from the
// register file with writeback bypass, and holds back RAW hazards via a pending-register scoreboard.
module r_issue_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output logic [4:0]      ex_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  localparam logic [6:0] OpReg  = 7'b0110011;
  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  logic [XLEN-1:0]      rf_q [REG_COUNT];
  logic [REG_COUNT-1:0] pend_q, pend_d;

  logic            ex_valid_q;
  logic [31:0]     ex_instr_q;
  logic [XLEN-1:0] ex_in1_q, ex_in2_q;
  logic [4:0]      ex_rd_q;
  logic            illegal_q;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;

  logic            legal;
  logic            wb_wr;
  logic            hit1, hit2;
  logic [XLEN-1:0] op1, op2;
  logic            haz1, haz2, hazard;
  logic            slot_free;
  logic            accept;
  logic            drop;

  always_comb begin
    opcode = in_instr[6:0];
    rd     = in_instr[11:7];
    f3     = in_instr[14:12];
    rs1    = in_instr[19:15];
    rs2    = in_instr[24:20];
    f7     = in_instr[31:25];
  end

  // Only the sub/sra variants may use the alternate funct7.
  assign legal = (opcode == OpReg) &&
                 ((f7 == F7Base) || ((f7 == F7Alt) && ((f3 == 3'b000) || (f3 == 3'b101))));

  assign wb_wr = wb_en && (wb_rd != 5'd0);
  assign hit1  = wb_en && (wb_rd == rs1);
  assign hit2  = wb_en && (wb_rd == rs2);

  always_comb begin
    op1 = '0;
    if (rs1 != 5'd0) begin
      op1 = hit1 ? wb_data : rf_q[rs1];
    end
  end

  always_comb begin
    op2 = '0;
    if (rs2 != 5'd0) begin
      op2 = hit2 ? wb_data : rf_q[rs2];
    end
  end

  // A producer retiring this very cycle no longer blocks its consumer.
  assign haz1   = (rs1 != 5'd0) && pend_q[rs1] && !hit1;
  assign haz2   = (rs2 != 5'd0) && pend_q[rs2] && !hit2;
  assign hazard = legal && (haz1 || haz2);

  assign slot_free = !ex_valid_q || ex_ready;
  assign in_ready  = legal ? (slot_free && !hazard) : 1'b1;
  assign accept    = in_valid && in_ready && legal;
  assign drop      = in_valid && !legal;

  // Clear first, then set, so a new producer of the same register stays outstanding.
  always_comb begin
    pend_d = pend_q;
    if (wb_wr) begin
      pend_d[wb_rd] = 1'b0;
    end
    if (accept && (rd != 5'd0)) begin
      pend_d[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_instr_q <= '0;
      ex_in1_q   <= '0;
      ex_in2_q   <= '0;
      ex_rd_q    <= '0;
      illegal_q  <= 1'b0;
      pend_q     <= '0;
    end else begin
      illegal_q <= drop;
      pend_q    <= pend_d;
      if (accept) begin
        ex_valid_q <= 1'b1;
        ex_instr_q <= in_instr;
        ex_in1_q   <= op1;
        ex_in2_q   <= op2;
        ex_rd_q    <= rd;
      end else if (ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_wr) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_instr_q;
  assign ex_in1   = ex_in1_q;
  assign ex_in2   = ex_in2_q;
  assign ex_rd    = ex_rd_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_r_issue_stage.sv
// Bench for r_issue_stage: directed scenarios plus randomized traffic, all checked every cycle
// against a behavioural model of register file, scoreboard and output slot.
module tb_r_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [4:0]  ex_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  always #5 clk = ~clk;

  r_issue_stage #(.XLEN(32), .REG_COUNT(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_instr (ex_instr),
    .ex_in1   (ex_in1),
    .ex_in2   (ex_in2),
    .ex_rd    (ex_rd),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .illegal  (illegal)
  );

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_exv;
  logic [31:0] m_exi, m_ex1, m_ex2;
  logic [4:0]  m_exrd;
  bit          m_ill;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] i);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    return (i[6:0] == 7'h33) && ((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
  endfunction

  function automatic logic [31:0] read_op(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit stalls(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic bit exp_ready();
    if (!is_legal(in_instr)) return 1'b1;
    return (!m_exv || ex_ready) && !stalls(in_instr[19:15]) && !stalls(in_instr[24:20]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_exv  = 1'b0;
    m_exi  = 32'd0;
    m_ex1  = 32'd0;
    m_ex2  = 32'd0;
    m_exrd = 5'd0;
    m_ill  = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic m_update();
    bit          acc;
    logic [31:0] o1, o2;
    logic [4:0]  rd;
    if (rst) begin
      m_reset();
      return;
    end
    acc   = in_valid && is_legal(in_instr) && exp_ready();
    o1    = read_op(in_instr[19:15]);
    o2    = read_op(in_instr[24:20]);
    rd    = in_instr[11:7];
    m_ill = in_valid && !is_legal(in_instr);
    if (acc) begin
      m_exv  = 1'b1;
      m_exi  = in_instr;
      m_ex1  = o1;
      m_ex2  = o2;
      m_exrd = rd;
    end else if (ex_ready) begin
      m_exv = 1'b0;
    end
    if (wb_en && wb_rd != 5'd0) begin
      m_rf[wb_rd]   = wb_data;
      m_pend[wb_rd] = 1'b0;
    end
    if (acc && rd != 5'd0) m_pend[rd] = 1'b1;
  endtask

  task automatic check_model();
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_exv});
    chk("ex_instr", ex_instr, m_exi);
    chk("ex_in1", ex_in1, m_ex1);
    chk("ex_in2", ex_in2, m_ex2);
    chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_exrd});
    chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
  endtask

  task automatic look();
    @(negedge clk);
    check_model();
  endtask

  task automatic step();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit er, input bit we,
                       input logic [4:0] wr, input logic [31:0] wd);
    in_valid = v;
    in_instr = ins;
    ex_ready = er;
    wb_en    = we;
    wb_rd    = wr;
    wb_data  = wd;
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned r;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    r   = $urandom_range(0, 9);
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    if (r == 0) return $urandom;
    if (r == 1) begin
      f7 = ($urandom_range(0, 1) == 0) ? 7'h01 : 7'h20;
      if (f7 == 7'h20) f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd7;
    end else begin
      f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
      if (f7 == 7'h20) f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
    end
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic rand_cycle();
    int          npend;
    logic [4:0]  cand [8];
    logic [4:0]  wr;
    npend = 0;
    for (int j = 1; j < 8; j++) begin
      if (m_pend[j]) begin
        cand[npend] = 5'(j);
        npend++;
      end
    end
    wr = 5'($urandom_range(0, 7));
    if (npend > 0 && $urandom_range(0, 9) < 7) wr = cand[$urandom_range(0, npend - 1)];
    drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, wr, $urandom);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
    m_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset ex_instr", ex_instr, 32'd0);
    chk("reset ex_in1", ex_in1, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;

    // Preload x1=5, x2=7, then add x3,x1,x2
    drive(0, 32'd0, 1, 1, 5'd1, 32'd5);            look(); step();
    drive(0, 32'd0, 1, 1, 5'd2, 32'd7);            look(); step();
    drive(1, 32'h002081B3, 1, 0, 5'd0, 32'd0);     look();
    chk("add accept ready", {31'd0, in_ready}, 32'd1);
    step();
    // add x4,x3,x1 must stall on x3
    drive(1, 32'h00118233, 1, 0, 5'd0, 32'd0);     look();
    chk("t1 ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("t1 ex_in1", ex_in1, 32'd5);
    chk("t1 ex_in2", ex_in2, 32'd7);
    chk("t1 ex_rd", {27'd0, ex_rd}, 32'd3);
    chk("t1 ex_instr", ex_instr, 32'h002081B3);
    chk("raw stall", {31'd0, in_ready}, 32'd0);
    step();
    look();
    chk("raw stall hold", {31'd0, in_ready}, 32'd0);
    step();
    drive(1, 32'h00118233, 1, 1, 5'd3, 32'd12);    look();
    chk("wb releases stall", {31'd0, in_ready}, 32'd1);
    step();
    drive(0, 32'd0, 0, 0, 5'd0, 32'd0);            look();
    chk("bypass ex_in1", ex_in1, 32'd12);
    chk("bypass ex_in2", ex_in2, 32'd5);
    chk("bypass ex_rd", {27'd0, ex_rd}, 32'd4);
    step();

    // Illegal: f7=0100000 with f3=001
    drive(1, 32'h402091B3, 0, 0, 5'd0, 32'd0);     look();
    chk("illegal ready", {31'd0, in_ready}, 32'd1);
    step();
    // Output slot held for three cycles with add x5,x3,x1 waiting
    drive(1, 32'h001182B3, 0, 0, 5'd0, 32'd0);     look();
    chk("illegal pulse", {31'd0, illegal}, 32'd1);
    chk("illegal keeps ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("illegal keeps ex_rd", {27'd0, ex_rd}, 32'd4);
    chk("slot busy", {31'd0, in_ready}, 32'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      look();
      chk("illegal one cycle", {31'd0, illegal}, 32'd0);
      chk("stall ex_in1 stable", ex_in1, 32'd12);
      chk("stall ready low", {31'd0, in_ready}, 32'd0);
      step();
    end
    drive(1, 32'h001182B3, 1, 0, 5'd0, 32'd0);     look();
    chk("slot frees, x3 not pending", {31'd0, in_ready}, 32'd1);
    step();
    // add x6,x0,x1 while writeback targets x0
    drive(1, 32'h00100333, 1, 1, 5'd0, 32'hFFFFFFFF); look();
    chk("x5 ex_rd", {27'd0, ex_rd}, 32'd5);
    chk("x5 ex_in1", ex_in1, 32'd12);
    chk("x0 no stall", {31'd0, in_ready}, 32'd1);
    step();
    drive(1, 32'h000003B3, 1, 0, 5'd0, 32'd0);     look();
    chk("x0 ex_in1", ex_in1, 32'd0);
    chk("x0 ex_in2", ex_in2, 32'd5);
    step();
    drive(0, 32'd0, 1, 0, 5'd0, 32'd0);            look();
    chk("x0 stays zero", ex_in1 | ex_in2, 32'd0);
    chk("x7 ex_rd", {27'd0, ex_rd}, 32'd7);
    step();

    for (int n = 0; n < 3000; n++) begin
      rand_cycle();
      look();
      step();
    end

    // Reset while an instruction is in flight and x3 is pending
    drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, 32'h002081B3, 0, 0, 5'd0, 32'd0);     look(); step();
    drive(0, 32'd0, 0, 0, 5'd0, 32'd0);            look();
    chk("pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
    rst = 1'b1;
    m_reset();
    drive(1, 32'h00118233, 1, 0, 5'd0, 32'd0);
    #1;
    chk("async reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async reset ex_instr", ex_instr, 32'd0);
    chk("async reset clears pend", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    look();
    step();
    drive(0, 32'd0, 1, 0, 5'd0, 32'd0);            look();
    chk("post-reset ex_rd", {27'd0, ex_rd}, 32'd4);
    chk("post-reset rf cleared", ex_in1 | ex_in2, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
